// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared op-code, state encodings and decode helpers for the mul/div unit
package md_defs;

    localparam int MD_CNT_W = 16;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for several cycles before HI/LO update.
    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// rtl/md_core.sv - combinational product / quotient-remainder datapath, result = {HI, LO}
module md_core
    import md_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      op,
    output logic [63:0] result
);

    logic        div_zero;
    logic        div_ovf;
    logic [31:0] div_safe;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        div_zero = (b == 32'h0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Substitute a harmless divisor so the dividers never see the corner cases.
        div_safe = (div_zero || div_ovf) ? 32'h1 : b;

        prod_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        prod_u = {32'h0, a} * {32'h0, b};

        q_s = $unsigned($signed(a) / $signed(div_safe));
        r_s = $unsigned($signed(a) % $signed(div_safe));
        q_u = a / div_safe;
        r_u = a % div_safe;
    end

    always_comb begin
        result = 64'h0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)     result = {a, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'h0, 32'h8000_0000};
                else              result = {r_s, q_s};
            end
            MD_DIVU: begin
                if (div_zero) result = {a, 32'hFFFF_FFFF};
                else          result = {r_u, q_u};
            end
            default:  result = 64'h0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle mult/div sequencer with HI/LO registers
module mul_div_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e            state_q, state_d;
    logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
    md_op_e               op_q, op_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic                 busy_q, busy_d;

    md_op_e               op_in;
    logic [63:0]          result;

    assign op_in = md_op_e'(MDop);

    md_core u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op_in)) begin
                        op_d    = op_in;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = is_div_op(op_in) ? DIV_LOAD : MULT_LOAD;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end else if (op_in == MD_MTHI) begin
                        hi_d = A;
                    end else if (op_in == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                // Starts are not looked at here, so a request on the completing edge is dropped.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port A  input  32  operand 1 (dividend / multiplicand / mthi-mtlo source).
REQ-006 SHALL have port B  input  32  operand 2 (divisor / multiplier).
REQ-007 SHALL have port MDop  input  3  operation code: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-008 SHALL have port start  input  1  request strobe, sampled on a rising clk edge together with MDop/A/B.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port HI  output  32  HI register (high product / remainder).
REQ-011 SHALL have port LO  output  32  LO register (low product / quotient).

Function
REQ-012 SHALL use states IDLE and RUN; HI, LO and busy are registered outputs driven directly from flops.
REQ-013 In IDLE, start=1 with MDop in {mult, multu, div, divu} SHALL latch A, B and MDop, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN; busy=1 from that edge.
REQ-014 In RUN, the counter SHALL decrement every edge; on the edge where it reaches 0, HI/LO SHALL be written and busy SHALL fall, so busy is high for exactly N cycles.
REQ-015 HI/LO SHALL hold their previous values for the whole of RUN and change only at the completing edge.
REQ-016 mult SHALL produce the signed 64-bit product {HI,LO} = $signed(A)*$signed(B); multu SHALL produce the unsigned 64-bit product.
REQ-017 div SHALL produce the signed quotient in LO, truncated toward zero, and the remainder in HI, carrying the sign of the dividend; divu SHALL produce the unsigned quotient and remainder.
REQ-018 When the divisor is zero, the unit SHALL set LO=32'hFFFFFFFF and HI=dividend A, for both div and divu.
REQ-019 div with 32'h80000000 / 32'hFFFFFFFF SHALL set LO=32'h80000000 and HI=0.
REQ-020 In IDLE, start=1 with mthi or mtlo SHALL write A to HI or LO respectively at that edge; busy SHALL stay 0.
REQ-021 Any start (including mthi/mtlo) while busy=1 SHALL be ignored, with no effect on state, operands or counter.
REQ-022 start=1 with MDop none/reserved SHALL be ignored.
REQ-023 A start SHALL be accepted on the same edge on which busy falls only if it occurs in the following cycle (no same-edge back-to-back); one idle-capable cycle separates consecutive operations.
REQ-024 Operand values on A/B after the accepting edge SHALL have no effect on the result.

Reset
REQ-025 reset=0 SHALL immediately and asynchronously force IDLE, busy=0, HI=0, LO=0 and counter=0, including mid-operation, where the operation SHALL be abandoned.
REQ-026 The first edge after reset deassertion SHALL be able to accept a start.

Structure
REQ-027 The MDop encodings and the IDLE/RUN state encodings SHALL live in the shared definitions package md_defs, which is reused by the controller decode.
REQ-028 The result computation SHALL be a combinational sub-module md_core (latched operands + op -> 64-bit result), with sequencing, counter and HI/LO registers kept in mul_div_unit.

Verification
REQ-029 mult A=32'hFFFFFFFD, B=7 -> busy high for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-030 multu A=32'hFFFFFFFD, B=7 -> after 5 cycles, HI=32'h00000006, LO=32'hFFFFFFEB.
REQ-031 div A=-7, B=2 -> busy high for 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu A=5, B=0 -> LO=32'hFFFFFFFF, HI=5.
REQ-032 During a mult, start with mthi A=32'h1234 and a second mult -> both ignored; only the first product appears, and HI is not 32'h1234.
REQ-033 Start div, then assert reset=0 after 4 cycles of busy -> busy=0, HI=LO=0 without waiting for a clock edge; after release, mtlo A=9 -> LO=9 next edge.
REQ-034 Idle mthi A=32'hCAFE then mtlo A=1 on consecutive edges -> HI=32'hCAFE, LO=1, and busy never asserts.
